// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-fill controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: fill FSM state enum, block geometry and the block-address mask.
package cache_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fill_state_t;

   localparam int          WORDS_PER_BLOCK = 8;
   localparam int          OFF_W           = 3;
   localparam logic [15:0] BLOCK_MASK      = 16'hFFF0;

endpackage

// File: rtl/fill_counter.sv
// Four-bit event counter that saturates at MAX, with synchronous clear.
// Latency: count updates on the clock edge after clr/inc.
// Backpressure: none; increments at MAX are dropped.
//
// Ports: clk, rst_n (async active-low), clr, inc -> cnt[3:0], full (cnt == MAX).
module fill_counter
   import cache_pkg::*;
#(
   parameter logic [3:0] MAX = 4'(WORDS_PER_BLOCK)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] cnt,
   output logic       full
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != MAX)) begin
         cnt <= cnt + 4'd1;
      end
   end

   assign full = (cnt == MAX);

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: stalls the core, reads one block from memory, writes data then tag.
// Latency: 10 + memory latency cycles of stall per miss (14 with a 4-cycle memory).
// Backpressure: none toward memory; the core is held off with fsm_busy for the whole fill.
//
// Optional feature: define CACHE_FILL_CWF_EN for critical-word-first ordering.
// Ports: clk, rst_n; miss_detected/miss_address from the cache lookup;
//        memory_data/memory_data_valid from main memory; mem_en/memory_address to memory;
//        write_data_array/data_word/fill_data and write_tag_array/block_base to the arrays;
//        fsm_busy stalls the processor.
module cache_fill_fsm #(
   parameter int WORDS_PER_BLOCK = 8,
   parameter int MEM_LATENCY     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        miss_detected,
   input  logic [15:0] miss_address,
   input  logic [15:0] memory_data,
   input  logic        memory_data_valid,
   output logic        fsm_busy,
   output logic        mem_en,
   output logic [15:0] memory_address,
   output logic        write_data_array,
   output logic [2:0]  data_word,
   output logic [15:0] fill_data,
   output logic        write_tag_array,
   output logic [15:0] block_base
);
   import cache_pkg::*;

   localparam logic [3:0] CNT_MAX = 4'(WORDS_PER_BLOCK);

   // Output widths assume an 8-word block; memory latency must be at least one cycle.
   if (WORDS_PER_BLOCK != 8 || MEM_LATENCY < 1) begin : g_cfg_err
      $error("cache_fill_fsm: unsupported WORDS_PER_BLOCK/MEM_LATENCY");
   end

   fill_state_t      state;
   logic [OFF_W-1:0] start_off;
   logic [3:0]       issue_cnt;
   logic [3:0]       recv_cnt;
   logic             issue_full;
   logic             recv_full;
   logic             fill_start;
   logic             rd_fire;
   logic             wr_fire;
   logic [OFF_W-1:0] issue_off;
   logic [OFF_W-1:0] recv_off;

   assign fill_start = (state == ST_IDLE) && miss_detected;
   assign rd_fire    = (state == ST_FILL) && !issue_full;
   assign wr_fire    = (state == ST_FILL) && memory_data_valid && !recv_full;

   // 3-bit adds wrap modulo the block, giving the critical-word-first rotation for free.
   assign issue_off  = start_off + issue_cnt[2:0];
   assign recv_off   = start_off + recv_cnt[2:0];

   fill_counter #(.MAX(CNT_MAX)) u_issue_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (fill_start),
      .inc   (rd_fire),
      .cnt   (issue_cnt),
      .full  (issue_full)
   );

   fill_counter #(.MAX(CNT_MAX)) u_recv_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (fill_start),
      .inc   (wr_fire),
      .cnt   (recv_cnt),
      .full  (recv_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         block_base <= '0;
         start_off  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (miss_detected) begin
                  block_base <= miss_address & BLOCK_MASK;
`ifdef CACHE_FILL_CWF_EN
                  start_off  <= miss_address[3:1];
`else
                  start_off  <= '0;
`endif
                  state      <= ST_FILL;
               end
            end
            ST_FILL: begin
               // Memory answers in issue order, so the last return closes the fill.
               if (wr_fire && (recv_cnt == CNT_MAX - 4'd1)) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Request/write strobes are decoded from registered state; address and offset are
   // forced to zero when idle so every output reads 0 while reset is held.
   assign mem_en           = rd_fire;
   assign memory_address   = rd_fire ? (block_base + {12'h000, issue_off, 1'b0}) : 16'h0000;
   assign write_data_array = wr_fire;
   assign data_word        = wr_fire ? recv_off : 3'd0;
   assign fill_data        = memory_data;
   assign write_tag_array  = (state == ST_DONE);

   // The miss cycle itself must stall, so the raw miss is folded in; masked during reset.
   assign fsm_busy = rst_n & ((state != ST_IDLE) | miss_detected);

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic [15:0] memory_data;
   logic        memory_data_valid;
   logic        fsm_busy;
   logic        mem_en;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic [2:0]  data_word;
   logic [15:0] fill_data;
   logic        write_tag_array;
   logic [15:0] block_base;

   cache_fill_fsm #(.WORDS_PER_BLOCK(8), .MEM_LATENCY(4)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data       (memory_data),
      .memory_data_valid (memory_data_valid),
      .fsm_busy          (fsm_busy),
      .mem_en            (mem_en),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .data_word         (data_word),
      .fill_data         (fill_data),
      .write_tag_array   (write_tag_array),
      .block_base        (block_base)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [15:0] addr;
   } mem_req_t;

   typedef struct {
      logic [2:0]  word;
      logic [15:0] data;
   } wr_exp_t;

   // Scoreboard queues filled at stimulus time, drained by the monitor.
   logic [15:0] exp_addr_q[$];
   wr_exp_t     exp_wr_q[$];
   logic [15:0] exp_tag_q[$];

   mem_req_t    pipe[$];
   int          cyc       = 0;
   int          lat       = 4;
   int          ret_cnt   = 0;
   int          ninth_due = -1;
   bit          model_idle = 1'b1;
   logic        busy_s;

   int          n_total  = 0;
   int          n_passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3A5;
   endfunction

   // Reference model: which words a miss at addr must request and write, in order.
   task automatic expect_fill(input logic [15:0] addr);
      logic [15:0] base;
      int          s;
      int          w;
      logic [15:0] wa;
      base = addr & 16'hFFF0;
`ifdef CACHE_FILL_CWF_EN
      s = int'(addr[3:1]);
`else
      s = 0;
`endif
      for (int i = 0; i < 8; i++) begin
         w  = (s + i) % 8;
         wa = base + 16'(w * 2);
         exp_addr_q.push_back(wa);
         exp_wr_q.push_back('{word: 3'(w), data: mem_fn(wa)});
      end
      exp_tag_q.push_back(base);
   endtask

   // One clock: drive memory returns for this cycle, apply miss inputs, sample at negedge.
   task automatic step(input logic m, input logic [15:0] a);
      @(posedge clk);
      #1;
      cyc++;
      if (pipe.size() > 0 && pipe[0].due == cyc) begin
         memory_data_valid = 1'b1;
         memory_data       = mem_fn(pipe[0].addr);
         void'(pipe.pop_front());
         ret_cnt++;
         if (ret_cnt == 8) begin
            ret_cnt   = 0;
            ninth_due = cyc + 1;
         end
      end else if (cyc == ninth_due || (model_idle && $urandom_range(0, 3) == 0)) begin
         memory_data_valid = 1'b1;
         memory_data       = 16'($urandom);
      end else begin
         memory_data_valid = 1'b0;
         memory_data       = 16'($urandom);
      end
      miss_detected = m;
      miss_address  = a;
      @(negedge clk);
      if (mem_en) pipe.push_back('{due: cyc + lat, addr: memory_address});
      busy_s = fsm_busy;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'($urandom));
   endtask

   task automatic do_fill(input logic [15:0] addr, input int l);
      int busy_cnt;
      int noise;
      lat      = l;
      busy_cnt = 0;
      expect_fill(addr);
      step(1'b1, addr);
      if (busy_s) busy_cnt++;
      model_idle = 1'b0;
      for (int k = 1; k < 60; k++) begin
         // Extra misses while busy must be ignored; none in the cycle the FSM returns to IDLE.
         noise = (k <= 9 + l && $urandom_range(0, 3) == 0) ? 1 : 0;
         step(noise != 0, 16'($urandom));
         if (busy_s) busy_cnt++;
         else break;
      end
      model_idle = 1'b1;
      check("stall_cycles", 32'(busy_cnt), 32'(10 + l));
      check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
      check("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);
      check("tag_q_drained", 32'(exp_tag_q.size()), 32'd0);
   endtask

   // Monitor: compares every DUT strobe against the head of its scoreboard queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_en) begin
            if (exp_addr_q.size() == 0) check("unexpected_mem_en", 32'(mem_en), 32'd0);
            else check("memory_address", 32'(memory_address), 32'(exp_addr_q.pop_front()));
         end
         if (write_data_array) begin
            if (exp_wr_q.size() == 0) begin
               check("unexpected_data_write", 32'(write_data_array), 32'd0);
            end else begin
               wr_exp_t e;
               e = exp_wr_q.pop_front();
               check("data_word", 32'(data_word), 32'(e.word));
               check("fill_data", 32'(fill_data), 32'(e.data));
            end
         end
         if (write_tag_array) begin
            if (exp_tag_q.size() == 0) check("unexpected_tag_write", 32'(write_tag_array), 32'd0);
            else check("block_base", 32'(block_base), 32'(exp_tag_q.pop_front()));
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_fsm_busy"}, 32'(fsm_busy), 32'd0);
      check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
      check({tag, "_memory_address"}, 32'(memory_address), 32'd0);
      check({tag, "_write_data_array"}, 32'(write_data_array), 32'd0);
      check({tag, "_data_word"}, 32'(data_word), 32'd0);
      check({tag, "_fill_data"}, 32'(fill_data), 32'd0);
      check({tag, "_write_tag_array"}, 32'(write_tag_array), 32'd0);
      check({tag, "_block_base"}, 32'(block_base), 32'd0);
   endtask

   initial begin
      rst_n             = 1'b0;
      miss_detected     = 1'b1;
      miss_address      = 16'h1234;
      memory_data       = 16'h0000;
      memory_data_valid = 1'b0;
      #3;
      check_all_zero("reset");
      #19;
      miss_detected = 1'b0;
      rst_n         = 1'b1;
      idle_cycles(3);

      // Directed cases: basic miss, top-of-memory block, then latency extremes.
      do_fill(16'h1234, 4);
      idle_cycles(2);
      do_fill(16'hFFFE, 4);
      idle_cycles(2);
      do_fill(16'h0000, 1);
      do_fill(16'hABCD, 6);

      // Reset in cycle 7 of a fill: outputs drop at once, no tag write follows.
      lat = 4;
      expect_fill(16'h4C5A);
      step(1'b1, 16'h4C5A);
      model_idle = 1'b0;
      for (int k = 1; k < 7; k++) step(1'b0, 16'h0000);
      @(posedge clk);
      #1;
      cyc++;
      memory_data_valid = 1'b0;
      memory_data       = 16'h0000;
      miss_detected     = 1'b1;
      rst_n             = 1'b0;
      #1;
      check_all_zero("midfill_reset");
      miss_detected = 1'b0;
      exp_addr_q.delete();
      exp_wr_q.delete();
      exp_tag_q.delete();
      pipe.delete();
      ret_cnt    = 0;
      ninth_due  = -1;
      model_idle = 1'b1;
      step(1'b0, 16'h0000);
      step(1'b0, 16'h0000);
      rst_n = 1'b1;
      idle_cycles(2);
      do_fill(16'h4C5A, 4);

      // Randomized misses with varying memory latency and idle gaps.
      for (int n = 0; n < 20; n++) begin
         idle_cycles($urandom_range(0, 3));
         do_fill(16'($urandom), $urandom_range(1, 6));
      end
      idle_cycles(4);

      check("final_pipe_empty", 32'(pipe.size()), 32'd0);
      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between the processor's cache arrays and main memory. On a cache miss it stalls the datapath and issues one read per block word to the multi-cycle main memory. It then steers each returned word into the cache data array and finally writes the tag. It sits directly beneath the processor's instruction/data memory port; the instruction fetch and the load/store path both consume the filled block.

## Interface
Parameters:
- WORDS_PER_BLOCK, 8: 16-bit words per cache block; block size 16 bytes.
- MEM_LATENCY, 4: main-memory read latency in cycles. Informational only; the FSM tracks returns by `memory_data_valid`.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- miss_detected  in  1  cache lookup missed this cycle. Sampled only in IDLE.
- miss_address  in  16  byte address of the missing access.
- memory_data  in  16  read data returned by main memory.
- memory_data_valid  in  1  `memory_data` valid this cycle.
- fsm_busy  out  1  stall request to the processor; PC write enable is gated by it.
- mem_en  out  1  read request to main memory this cycle.
- memory_address  out  16  word-aligned read address for the request.
- write_data_array  out  1  write `fill_data` into the data array this cycle.
- data_word  out  3  word offset within the block for the data-array write.
- fill_data  out  16  data to write (`memory_data` passed through).
- write_tag_array  out  1  write tag/valid for `block_base` this cycle.
- block_base  out  16  captured block address, `miss_address & 16'hFFF0`.

## Operation
States:
- IDLE: no fill in progress.
  - When `miss_detected` is high: capture `block_base`, set `start_off`, clear `issue_cnt` and `recv_cnt`, go to FILL.
- FILL:
  - While `issue_cnt < 8`: `mem_en` = 1, `memory_address` = `block_base` + (((`start_off` + `issue_cnt`) mod 8) << 1); then `issue_cnt`++.
  - On each `memory_data_valid` with `recv_cnt < 8`: `write_data_array` = 1, `data_word` = (`start_off` + `recv_cnt`) mod 8; then `recv_cnt`++.
  - The valid that makes `recv_cnt` = 8 moves the FSM to DONE.
- DONE: `write_tag_array` = 1 for exactly one cycle, then IDLE.

Output rules:
- `fsm_busy` = (state != IDLE) | (state == IDLE & `miss_detected`). It is combinational, so the miss cycle itself stalls.
- Memory returns data in issue order. `fill_data` = `memory_data` combinationally.
- Offset arithmetic is 3-bit and wraps modulo 8. Address arithmetic is 16-bit; no carry out of bit 3 is possible.

Boundary conditions:
- `memory_data_valid` in IDLE or DONE, or after `recv_cnt` = 8: ignored, no array write.
- `miss_detected` in FILL or DONE: ignored. The cache re-presents the miss after the FSM returns to IDLE.
- Valid arriving in the same cycle as an issue is handled: both counters advance independently.
- `miss_address` = 16'hFFFE: `block_base` = 16'hFFF0; addresses stay within the block.
- Reset mid-fill: immediately IDLE, counters 0, every output 0. No tag write, so the partial block stays invalid.

## Timing
- Reset value of every output: 0.
- Miss in cycle 0 (IDLE, `fsm_busy` high combinationally).
- FILL runs from cycle 1; issues occur in cycles 1–8.
- With a latency-4 memory, valids arrive in cycles 5–12.
- DONE in cycle 13; IDLE in cycle 14.
- Total stall: 14 cycles.
- `write_data_array` is aligned to `memory_data_valid` with zero latency.

## Configuration
- CACHE_FILL_CWF_EN defined: critical-word-first ordering, `start_off` = `miss_address[3:1]`. The missing word is requested first and later words wrap modulo 8.
- CACHE_FILL_CWF_EN undefined: `start_off` = 0, so words are filled in offset order 0..7 regardless of `miss_address`.

## Structure
- Package `cache_pkg`:
  - FSM state enum (IDLE, FILL, DONE).
  - WORDS_PER_BLOCK.
  - Block-offset width (3).
  - Block mask constant 16'hFFF0.
- Sub-module `fill_counter`: 4-bit saturating-at-8 counter with clear and increment.
  - Instantiated twice, once for issue and once for receive.

## Test plan
- Miss at 16'h1234 with CWF off, latency-4 memory:
  - `memory_address` 16'h1230, 1232, …, 123E in cycles 1–8.
  - `write_data_array` in cycles 5–12 with `data_word` 0..7.
  - `write_tag_array` in cycle 13.
  - `fsm_busy` low in cycle 14.
- Same miss with CWF on: addresses 16'h1234, 1236, …, 123E, 1230, 1232; `data_word` sequence 2,3,4,5,6,7,0,1.
- Miss at 16'hFFFE: `block_base` 16'hFFF0; all addresses within FFF0–FFFE; no wrap to 0000.
- Spurious `memory_data_valid` in IDLE and a ninth valid in DONE: no array writes.
- New `miss_detected` during FILL: ignored; exactly one tag write.
- `rst_n` low in cycle 7 of a fill: all outputs 0 asynchronously; no `write_tag_array`. A fresh miss after release completes normally in 14 cycles.
